// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: line widths, arbiter FSM
// states and owner encodings used by the L1/L2 cache arbiter.
package lc3b_types;

    typedef logic [11:0]  lc3b_line_addr;
    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_line_sel;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } cache_arb_state_t;

    localparam logic ARB_OWNER_I = 1'b0;
    localparam logic ARB_OWNER_D = 1'b1;

    typedef struct packed {
        lc3b_line_addr adr;
        lc3b_line      dat;
        logic          we;
        lc3b_line_sel  sel;
    } arb_req_t;

    function automatic logic arb_other(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/wishbone.sv
// Line-granular wishbone port between L1 caches, the arbiter and L2.
// The master drives the request; the slave returns data and ACK.
interface wishbone;
    import lc3b_types::*;

    lc3b_line_addr ADR;
    lc3b_line      DAT_M;
    lc3b_line      DAT_S;
    logic          WE;
    logic          STB;
    logic          CYC;
    lc3b_line_sel  SEL;
    logic          ACK;

    modport master (
        output ADR, DAT_M, WE, STB, CYC, SEL,
        input  DAT_S, ACK
    );

    modport slave (
        input  ADR, DAT_M, WE, STB, CYC, SEL,
        output DAT_S, ACK
    );

endinterface

// File: rtl/cache_arb_pick.sv
// Combinational winner selection for the cache arbiter.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin; default is D-side priority.
module cache_arb_pick
    import lc3b_types::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_last,
    output logic o_gnt,
    output logic o_win
);

    assign o_gnt = i_req_i | i_req_d;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_win = ARB_OWNER_I;
        unique case (1'b1)
            (i_req_i && i_req_d): o_win = arb_other(i_last);
            i_req_d:              o_win = ARB_OWNER_D;
            default:              o_win = ARB_OWNER_I;
        endcase
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign o_win = i_req_d ? ARB_OWNER_D : ARB_OWNER_I;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one L2 wishbone port between I- and D-side L1 caches.
// Optional round-robin arbitration via CACHE_ARB_ROUND_ROBIN_EN.
module cache_arbiter
    import lc3b_types::*;
(
    input  logic    clk,
    input  logic    rst_n,
    wishbone.slave  icache,
    wishbone.slave  dcache,
    wishbone.master l2
);

    cache_arb_state_t r_state;
    cache_arb_state_t w_next;

    logic     r_owner;
    arb_req_t r_req;
    lc3b_line r_resp;

    logic     w_vi;
    logic     w_vd;
    logic     w_gnt;
    logic     w_win;
    logic     w_last;
    logic     w_take;
    arb_req_t w_ireq;
    arb_req_t w_dreq;

    assign w_vi   = icache.STB & icache.CYC;
    assign w_vd   = dcache.STB & dcache.CYC;
    assign w_take = (r_state == IDLE) & w_gnt;

    always_comb begin
        w_ireq     = '0;
        w_ireq.adr = icache.ADR;
        w_ireq.dat = icache.DAT_M;
        w_ireq.we  = icache.WE;
        w_ireq.sel = icache.SEL;
        w_dreq     = '0;
        w_dreq.adr = dcache.ADR;
        w_dreq.dat = dcache.DAT_M;
        w_dreq.we  = dcache.WE;
        w_dreq.sel = dcache.SEL;
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= ARB_OWNER_D;
        end else if (w_take) begin
            r_last <= w_win;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = ARB_OWNER_D;
`endif

    cache_arb_pick u_pick (
        .i_req_i (w_vi),
        .i_req_d (w_vd),
        .i_last  (w_last),
        .o_gnt   (w_gnt),
        .o_win   (w_win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_gnt) w_next = BUSY;
            BUSY:    if (l2.ACK) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request is latched once at grant; L2 never sees live L1 inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= ARB_OWNER_I;
            r_req   <= '0;
            r_resp  <= '0;
        end else begin
            if (w_take) begin
                r_owner <= w_win;
                r_req   <= (w_win == ARB_OWNER_D) ? w_dreq : w_ireq;
            end
            if ((r_state == BUSY) && l2.ACK) begin
                r_resp <= l2.DAT_S;
            end
        end
    end

    always_comb begin
        l2.STB       = 1'b0;
        l2.CYC       = 1'b0;
        l2.WE        = 1'b0;
        l2.ADR       = r_req.adr;
        l2.DAT_M     = r_req.dat;
        l2.SEL       = r_req.sel;
        icache.ACK   = 1'b0;
        dcache.ACK   = 1'b0;
        icache.DAT_S = r_resp;
        dcache.DAT_S = r_resp;
        unique case (r_state)
            BUSY: begin
                l2.STB = 1'b1;
                l2.CYC = 1'b1;
                l2.WE  = r_req.we;
            end
            RESP: begin
                icache.ACK = (r_owner == ARB_OWNER_I) & icache.STB;
                dcache.ACK = (r_owner == ARB_OWNER_D) & dcache.STB;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed cases plus random traffic.
// Inputs driven on negedge, outputs sampled 1 time unit after posedge.
module tb_cache_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wishbone ic ();
    wishbone dc ();
    wishbone l2w ();

    cache_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (ic),
        .dcache (dc),
        .l2     (l2w)
    );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0]  q_adr [2];
    logic [127:0] q_dat [2];
    logic         q_we  [2];
    logic [15:0]  q_sel [2];
    int           raise_cyc [2];

    bit           own_q [$];
    logic [127:0] dat_q [$];
    bit           gnt_log [$];

    int cyc = 0;
    int n_done = 0;
    int last_start = 0;
    int last_gap = 0;
    int fix_lat = -1;
    bit fix_dat = 1'b0;

    localparam logic [127:0] BEEF = {16'hDEAD, 96'h0, 16'hBEEF};

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic put(input int p, input bit stb, input logic [11:0] a,
                       input logic [127:0] d, input bit we,
                       input logic [15:0] sel);
        q_adr[p] = a;
        q_dat[p] = d;
        q_we[p]  = we;
        q_sel[p] = sel;
        if (p == 0) begin
            ic.ADR = a; ic.DAT_M = d; ic.WE = we; ic.SEL = sel;
            ic.STB = stb; ic.CYC = stb;
        end else begin
            dc.ADR = a; dc.DAT_M = d; dc.WE = we; dc.SEL = sel;
            dc.STB = stb; dc.CYC = stb;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin
            ic.STB = 1'b0; ic.CYC = 1'b0;
        end else begin
            dc.STB = 1'b0; dc.CYC = 1'b0;
        end
    endtask

    function automatic bit acked(input int p);
        return (p == 0) ? ic.ACK : dc.ACK;
    endfunction

    // Called on a negedge; raises the request and holds it until ACK.
    task automatic req(input int p, input logic [11:0] a,
                       input logic [127:0] d, input bit we,
                       input logic [15:0] sel, output logic [127:0] got);
        bit ok = 1'b0;
        got = '0;
        put(p, 1'b1, a, d, we, sel);
        raise_cyc[p] = cyc;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (acked(p)) begin
                got = (p == 0) ? ic.DAT_S : dc.DAT_S;
                ok = 1'b1;
            end
        end
        drop(p);
        check($sformatf("req_ack_p%0d", p), ok, 1'b1);
    endtask

    // L2 model: ACK after a programmable or random wait.
    initial begin
        int  cnt;
        bit  infl;
        cnt = 0;
        infl = 1'b0;
        l2w.ACK = 1'b0;
        l2w.DAT_S = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                l2w.ACK = 1'b0;
                infl = 1'b0;
            end else if (l2w.ACK) begin
                l2w.ACK = 1'b0;
            end else if (l2w.STB) begin
                if (!infl) begin
                    infl = 1'b1;
                    cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
                end
                if (cnt == 0) begin
                    l2w.ACK = 1'b1;
                    l2w.DAT_S = fix_dat ? BEEF :
                                {$urandom, $urandom, $urandom, $urandom};
                    dat_q.push_back(l2w.DAT_S);
                    infl = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: predicts the winner, checks L2 request and upstream ACK.
    initial begin
        bit ps;
        bit pa;
        bit mlast;
        int last_ack;
        ps = 1'b0;
        pa = 1'b0;
        mlast = 1'b1;
        last_ack = -100;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                own_q.delete();
                dat_q.delete();
                ps = 1'b0;
                pa = 1'b0;
                mlast = 1'b1;
                last_ack = -100;
                check("rst_l2_ctl", {l2w.STB, l2w.CYC, l2w.WE}, 3'b000);
                check("rst_acks", {ic.ACK, dc.ACK}, 2'b00);
                check("rst_adr", l2w.ADR, 12'h0);
                check("rst_resp", ic.DAT_S, 128'h0);
            end else begin
                if (pa) check("l2_stb_drop", l2w.STB, 1'b0);
                if (l2w.STB && !ps) begin
                    bit vi;
                    bit vd;
                    bit w;
                    vi = ic.STB & ic.CYC;
                    vd = dc.STB & dc.CYC;
                    check("grant_valid", vi | vd, 1'b1);
                    if (vi && vd) w = RR ? ~mlast : 1'b1;
                    else          w = vd;
                    mlast = w;
                    check("l2_adr", l2w.ADR, q_adr[w]);
                    check("l2_datm", l2w.DAT_M, q_dat[w]);
                    check("l2_we", l2w.WE, q_we[w]);
                    check("l2_sel", l2w.SEL, q_sel[w]);
                    last_gap = cyc - last_ack;
                    if (last_gap < 2) check("idle_gap", last_gap, 2);
                    last_start = cyc;
                    own_q.push_back(w);
                    gnt_log.push_back(w);
                end
                if (l2w.ACK) begin
                    bit o;
                    logic [127:0] d;
                    bit ei;
                    bit ed;
                    n_done++;
                    last_ack = cyc;
                    if (own_q.size() == 0 || dat_q.size() == 0) begin
                        check("sb_underflow", 1'b0, 1'b1);
                    end else begin
                        o = own_q.pop_front();
                        d = dat_q.pop_front();
                        ei = (o == 1'b0) & ic.STB;
                        ed = (o == 1'b1) & dc.STB;
                        check("up_acks", {ic.ACK, dc.ACK}, {ei, ed});
                        if (ei) check("i_dats", ic.DAT_S, d);
                        if (ed) check("d_dats", dc.DAT_S, d);
                    end
                end else if (ic.ACK || dc.ACK) begin
                    check("stray_ack", {ic.ACK, dc.ACK}, 2'b00);
                end
                ps = l2w.STB;
                pa = l2w.ACK;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] g0;
        logic [127:0] g1;
        int           d0;
        bit           exp_seq [6];
        rst_n = 1'b0;
        put(0, 1'b0, '0, '0, 1'b0, '0);
        put(1, 1'b0, '0, '0, 1'b0, '0);
        do_reset(3);

        // Single I-read with fixed L2 latency and data.
        fix_lat = 3;
        fix_dat = 1'b1;
        req(0, 12'h123, 128'h0, 1'b0, 16'hFFFF, g0);
        check("t1_data", g0, BEEF);
        check("t1_latency", last_start, raise_cyc[0] + 1);
        fix_dat = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous I-read and D-write.
        d0 = n_done;
        fork
            req(0, 12'h010, 128'h0, 1'b0, 16'hFFFF, g0);
            req(1, 12'h020, {4{32'hA5A5_5A5A}}, 1'b1, 16'h0003, g1);
        join
        check("t2_count", n_done - d0, 2);
        repeat (2) @(negedge clk);

        // Both ports streaming three requests each after reset.
        do_reset(1);
        gnt_log.delete();
        fork
            for (int i = 0; i < 3; i++)
                req(0, 12'h100 + 12'(i), 128'(i), 1'b0, 16'hFFFF, g0);
            for (int i = 0; i < 3; i++)
                req(1, 12'h200 + 12'(i), 128'(i), 1'b1, 16'h00F0, g1);
        join
        for (int i = 0; i < 6; i++)
            exp_seq[i] = RR ? ((i % 2) == 1) : (i < 3);
        check("t3_len", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            check($sformatf("t3_gnt%0d", i), gnt_log[i], exp_seq[i]);
        repeat (2) @(negedge clk);

        // I withdraws during BUSY.
        d0 = n_done;
        put(0, 1'b1, 12'h055, 128'h55, 1'b0, 16'hFFFF);
        for (int i = 0; i < 50 && !l2w.STB; i++) @(negedge clk);
        check("t4_busy", l2w.STB, 1'b1);
        drop(0);
        for (int i = 0; i < 50 && n_done == d0; i++) @(negedge clk);
        check("t4_l2_done", n_done - d0, 1);
        repeat (3) @(negedge clk);
        check("t4_sb_empty", own_q.size(), 0);
        req(1, 12'h066, 128'h66, 1'b0, 16'hFFFF, g1);

        // Reset pulse during BUSY; held request is reissued.
        put(0, 1'b1, 12'h0AB, 128'hAB, 1'b1, 16'h0F0F);
        for (int i = 0; i < 50 && !l2w.STB; i++) @(negedge clk);
        check("t5_busy", l2w.STB, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 0;
        for (int i = 0; i < 50 && d0 == 0; i++) begin
            @(negedge clk);
            if (ic.ACK) d0 = 1;
        end
        drop(0);
        check("t5_regrant", d0, 1);
        repeat (2) @(negedge clk);

        // D arrives during I's BUSY; must wait for k+2.
        fix_lat = 2;
        begin
            bit di;
            bit dd;
            di = 1'b0;
            dd = 1'b0;
            put(0, 1'b1, 12'h111, 128'h11, 1'b0, 16'hFFFF);
            @(negedge clk);
            put(1, 1'b1, 12'h222, 128'h22, 1'b0, 16'hFFFF);
            for (int i = 0; i < 100 && !(di && dd); i++) begin
                @(negedge clk);
                if (!di && ic.ACK) begin di = 1'b1; drop(0); end
                if (!dd && dc.ACK) begin dd = 1'b1; drop(1); end
            end
            check("t6_done", {di, dd}, 2'b11);
            check("t6_gap", last_gap, 2);
        end
        repeat (2) @(negedge clk);

        // Random traffic from both sides.
        fix_lat = -1;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                req(0, 12'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom), 16'($urandom), g0);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                req(1, 12'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom), 16'($urandom), g1);
            end
        join
        repeat (5) @(negedge clk);
        check("end_own_q", own_q.size(), 0);
        check("end_dat_q", dat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
